// File: rtl/prio_enc_rr.sv
// rtl/prio_enc_rr.sv - parametrised fixed/round-robin priority encoder with valid/ready handshake
// One result register; a new request is accepted whenever the result slot is empty or being drained.
module prio_enc_rr #(
  parameter int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mode,
  input  logic [N-1:0] D,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] Q,
  output logic         zero,
  output logic         multi,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] q_q, q_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic         zero_q, zero_d;
  logic         multi_q, multi_d;
  logic         out_valid_q, out_valid_d;

  logic [W-1:0] fix_idx, rr_hi_idx, rr_lo_idx;
  logic         any_set, hi_found, multi_c, capture;

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready;

  // Round-robin pick: lowest set bit at or above ptr, else lowest set bit overall.
  always_comb begin
    fix_idx   = '0;
    rr_hi_idx = '0;
    rr_lo_idx = '0;
    any_set   = 1'b0;
    hi_found  = 1'b0;
    multi_c   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (D[i]) begin
        if (any_set) multi_c = 1'b1;
        if (!any_set) rr_lo_idx = W'(i);
        if (!hi_found && (i >= int'(ptr_q))) begin
          hi_found  = 1'b1;
          rr_hi_idx = W'(i);
        end
        fix_idx = W'(i);
        any_set = 1'b1;
      end
    end
  end

  always_comb begin
    q_d         = q_q;
    zero_d      = zero_q;
    multi_d     = multi_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (capture) begin
      out_valid_d = 1'b1;
      zero_d      = !any_set;
      multi_d     = multi_c;
      q_d         = mode ? (hi_found ? rr_hi_idx : rr_lo_idx) : fix_idx;
      // Wrap at N rather than 2^W so non-power-of-2 sizes never point past the last line.
      if (mode && any_set) ptr_d = (q_d == W'(N - 1)) ? '0 : q_d + W'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q         <= '0;
      zero_q      <= 1'b0;
      multi_q     <= 1'b0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      q_q         <= q_d;
      zero_q      <= zero_d;
      multi_q     <= multi_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign Q         = q_q;
  assign zero      = zero_q;
  assign multi     = multi_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/prio_enc_rr.md
Name: prio_enc_rr

Overview:
- Parametrised N-to-log2(N) encoder; successor to the fixed 8-to-3 encoder.
- Adds a registered output, a valid/ready handshake on both sides, and run-time selectable fixed or round-robin priority.
- Adds zero-input and multi-hot status flags.
- Sits between a request vector source (interrupt lines, channel requests) and a consumer that needs one index per transfer.

Parameters:
- N, 8, number of request inputs; legal range 2..256.
- W, derived localparam = clog2(N); width of Q. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- mode  in  1  0 = fixed priority (highest index wins); 1 = round-robin.
- D  in  N  request vector.
- in_valid  in  1  D is valid this cycle.
- in_ready  out  1  block can accept D this cycle.
- Q  out  W  encoded index.
- zero  out  1  captured D was all zeros.
- multi  out  1  captured D had more than one bit set.
- out_valid  out  1  Q/zero/multi hold a result.
- out_ready  in  1  consumer accepts the result this cycle.

Behaviour:
- Reset (rst_n low at a clk edge, regardless of other inputs):
  - Q=0, zero=0, multi=0, out_valid=0, internal pointer ptr=0.
  - Any pending result is discarded.
- in_ready is combinational: in_ready = !out_valid || out_ready.
- Capture occurs when in_valid && in_ready at a clk edge:
  - next cycle: out_valid=1; Q, zero and multi are computed from the D sampled at that edge.
  - latency is 1 cycle.
- Drain: out_valid && out_ready && no capture at the same edge -> out_valid=0. Q, zero and multi hold their last values.
- Capture and drain at the same edge -> out_valid stays 1 and takes the new result (back-to-back, full throughput).
- out_valid && !out_ready:
  - Q, zero, multi and out_valid are all held; in_ready=0.
  - D and in_valid are ignored.
- Fixed mode (mode=0): Q = highest set index of D.
- Round-robin mode (mode=1):
  - Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1; Q = first set bit found.
  - On capture of a non-zero D: ptr <= (Q+1) mod N, wrapping at N, not 2^W.
- ptr updates only on a round-robin capture with non-zero D. It is unchanged in fixed mode, on zero D, and while stalled.
- mode is sampled at capture; changing mode never resets ptr.
- Zero D: Q=0, zero=1, multi=0; out_valid still asserts (result is a valid "none" response).
- multi = (popcount(D) >= 2), independent of mode.
- For N not a power of 2, Q never exceeds N-1.
- X on D while in_valid=0 has no effect on any output or on ptr.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with in_valid=1, D=8'hFF, out_ready=1.
   - During reset: out_valid=0, Q=0, zero=0, multi=0.
   - First cycle after release: in_ready=1.
2. Fixed one-hot sweep: mode=0, out_ready=1, in_valid=1, D=1<<i for i=0..7, then D=0.
   - Q=i exactly one cycle after each D, multi=0.
   - For D=0: Q=0, zero=1.
   - out_valid stays 1 continuously.
3. Fixed multi-hot: mode=0, D=8'b00010010.
   - Q=4, multi=1, zero=0.
   - Then D=8'b11111111 -> Q=7, multi=1.
4. Round-robin rotation: mode=1 after reset, D=8'b10010010 held, in_valid=1, out_ready=1.
   - Q sequence 1,4,7,1,4,7, with ptr wrapping 8 -> 0.
   - Insert D=0 mid-sequence -> zero=1, and the next non-zero result continues the rotation unchanged.
5. Backpressure: capture D=8'b00000100 (Q=2), then out_ready=0 for 4 cycles while D=8'b10000000, in_valid=1.
   - Q=2 held, in_ready=0 throughout.
   - Raise out_ready=1 -> capture at that edge -> next cycle Q=7, out_valid=1.
6. N=5, round-robin, non-power-of-2 wrap: D=5'b10001 held.
   - Q sequence 0,4,0,4; Q never exceeds 4.
   - Assert rst_n=0 while out_valid=1 -> out_valid=0 next cycle, ptr=0, next capture gives Q=0.
